// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first serialiser.
// Frames go out back-to-back with no idle gap while bytes are queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data_in,
  input  logic                         data_valid,
  output logic                         data_ready,
  output logic                         txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         r_state;
  logic [DW-1:0]  r_div;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_txd;
  logic           r_busy;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic [7:0]     r_mem [FIFO_DEPTH];

  state_t         w_state_nxt;
  logic [DW-1:0]  w_div_nxt;
  logic [2:0]     w_bit_nxt;
  logic [7:0]     w_shift_nxt;
  logic           w_txd_nxt;
  logic           w_busy_nxt;
  logic [LW-1:0]  w_level_nxt;
  logic           w_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_div_zero;
  logic           w_queued;

  assign w_ready    = (r_level != LEVEL_FULL);
  assign w_push     = data_valid && w_ready;
  assign w_div_zero = (r_div == '0);
  assign w_queued   = (r_level != '0);

  // Next-state, serialiser and pop decision; txd is computed one edge ahead of the pin.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_queued) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_bit_nxt   = '0;
          w_div_nxt   = DIV_RELOAD;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_div_zero) begin
          w_state_nxt = S_DATA;
          w_div_nxt   = DIV_RELOAD;
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end else begin
          w_div_nxt = r_div - DW'(1);
        end
      end
      S_DATA: begin
        if (w_div_zero) begin
          w_div_nxt = DIV_RELOAD;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
          end
        end else begin
          w_div_nxt = r_div - DW'(1);
        end
      end
      S_STOP: begin
        if (w_div_zero) begin
          if (w_queued) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_bit_nxt   = '0;
            w_div_nxt   = DIV_RELOAD;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_div_nxt = r_div - DW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase

    w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    w_busy_nxt  = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
      r_level   <= w_level_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= data_in;
  end

  assign data_ready = w_ready;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign level      = r_level;

endmodule
